mdu_param: RTL and testbench

MDU_PARAM -- requirements
Module: mdu_param

---
 rtl/mdu_param.sv | 163 ++++++++++++++++
 tb/tb_mdu_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and a fixed-latency busy window.
// Define MDU_MADD_ACCUM_EN to enable the madd/maddu/msub/msubu accumulate ops (codes 6..9).
module mdu_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(32);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_ACCUM_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shadow_hi, shadow_lo;
  logic             shadow_we;
  logic             commit, wr_hi, wr_lo;

  logic                 is_mult, is_div, is_signed, is_acc, is_sub;
  logic [2*WIDTH-1:0]   a_ext, b_ext, product, acc, mult_res;
  logic                 a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    is_mult   = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_acc    = 1'b0;
    is_sub    = 1'b0;
    case (op)
      OP_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mult = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_ACCUM_EN
      OP_MADD:  begin is_mult = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mult = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_mult = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      OP_MSUBU: begin is_mult = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Signed products come from sign-extending both operands and keeping the low 2*WIDTH bits.
  always_comb begin
    a_ext    = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext    = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    product  = a_ext * b_ext;
    acc      = {hi, lo};
    mult_res = is_acc ? (is_sub ? acc - product : acc + product) : product;
  end

  // Magnitude divide then re-sign; MIN_INT / -1 wraps naturally to MIN_INT with remainder 0.
  always_comb begin
    a_neg    = is_signed & a[WIDTH-1];
    b_neg    = is_signed & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    start      = op_valid & (is_mult | is_div) & ~busy & ~kill;
    wr_hi      = op_valid & (op == OP_MTHI) & ~busy & ~kill;
    wr_lo      = op_valid & (op == OP_MTLO) & ~busy & ~kill;
    commit     = 1'b0;
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          cnt_next   = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
      end
      BUSY: begin
        if (kill) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          commit     = shadow_we;
        end else begin
          cnt_next   = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The result is computed at acceptance and parked until the busy window closes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_hi <= '0;
      shadow_lo <= '0;
      shadow_we <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (start) begin
        shadow_hi <= is_div ? rem  : mult_res[2*WIDTH-1:WIDTH];
        shadow_lo <= is_div ? quot : mult_res[WIDTH-1:0];
        shadow_we <= ~(is_div & div_zero);
      end else if (busy && kill) begin
        shadow_hi <= '0;
        shadow_lo <= '0;
        shadow_we <= 1'b0;
      end
      if (commit) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end else begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench for mdu_param: driver pushes expected HI/LO and busy length, monitor checks at busy fall.
// Follows MDU_MADD_ACCUM_EN to decide whether codes 6..9 are accumulate ops or no-ops.
module tb_mdu_param;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        kill = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        start, busy;
  logic [31:0] hi, lo;

  mdu_param #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .kill(kill), .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          passed = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference behaviour straight from the arithmetic rules, using 64-bit integer math.
  function automatic void model_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                   output bit multi, output logic [31:0] nh, output logic [31:0] nl);
    logic [63:0] prod, accv, res;
    longint      sa, sb, q, r;
    multi = 1'b0;
    nh    = model_hi;
    nl    = model_lo;
    accv  = {model_hi, model_lo};
    sa    = longint'($signed(av));
    sb    = longint'($signed(bv));
    case (o)
      4'd0: begin multi = 1'b1; prod = 64'(sa * sb); {nh, nl} = prod; end
      4'd1: begin multi = 1'b1; prod = {32'd0, av} * {32'd0, bv}; {nh, nl} = prod; end
      4'd2: begin
        multi = 1'b1;
        if (bv != 0) begin
          q = sa / sb; r = sa % sb;
          nl = q[31:0]; nh = r[31:0];
        end
      end
      4'd3: begin
        multi = 1'b1;
        if (bv != 0) begin
          nl = av / bv; nh = av % bv;
        end
      end
      4'd4: nh = av;
      4'd5: nl = av;
`ifdef MDU_MADD_ACCUM_EN
      4'd6: begin multi = 1'b1; res = accv + 64'(sa * sb); {nh, nl} = res; end
      4'd7: begin multi = 1'b1; res = accv + {32'd0, av} * {32'd0, bv}; {nh, nl} = res; end
      4'd8: begin multi = 1'b1; res = accv - 64'(sa * sb); {nh, nl} = res; end
      4'd9: begin multi = 1'b1; res = accv - {32'd0, av} * {32'd0, bv}; {nh, nl} = res; end
`endif
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("[TB] FAIL wait_idle: busy stuck at %b after %0d cycles, required 0", busy, n);
    end
  endtask

  // kill_cycle > 0 asserts kill during that busy cycle; kill_issue asserts kill alongside the op.
  task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                input bit kill_issue, input int kill_cycle);
    bit          multi;
    logic [31:0] nh, nl;
    exp_t        item;
    wait_idle();
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; a = av; b = bv; kill = kill_issue;
    model_op(o, av, bv, multi, nh, nl);
    if (kill_issue) begin
      multi = 1'b0; nh = model_hi; nl = model_lo;
    end
    #2;
    check_output($sformatf("start op%0d", o), 32'(start), 32'(multi));
    if (multi) begin
      if (kill_cycle > 0) begin
        item.len = kill_cycle; item.hi = model_hi; item.lo = model_lo;
      end else begin
        item.len = (o == 4'd2 || o == 4'd3) ? DIV_LAT : MULT_LAT;
        item.hi = nh; item.lo = nl;
      end
      exp_q.push_back(item);
      model_hi = item.hi; model_lo = item.lo;
    end else begin
      model_hi = nh; model_lo = nl;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; kill = 1'b0;
    if (!multi) begin
      check_output($sformatf("hi after op%0d", o), hi, model_hi);
      check_output($sformatf("lo after op%0d", o), lo, model_lo);
      check_output("busy after immediate op", 32'(busy), 32'(0));
    end else if (kill_cycle > 0) begin
      repeat (kill_cycle - 1) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
    end
  endtask

  // Monitor: each busy window closing is a presented result.
  initial begin : monitor
    bit   prev_busy = 1'b0;
    int   run = 0;
    exp_t item;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        run = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) run++;
        else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("[TB] FAIL unexpected_result: busy window of %0d closed, required none", run);
          end else begin
            item = exp_q.pop_front();
            check_output("busy length", 32'(run), 32'(item.len));
            check_output("hi result", hi, item.hi);
            check_output("lo result", lo, item.lo);
          end
          run = 0;
        end
        prev_busy = busy;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && busy && op_valid) begin
      total++;
      $display("[TB] FAIL op_while_busy: op_valid=%b with busy=%b, required no op while busy", op_valid, busy);
    end
  end

  initial begin : driver
    int          n;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    bit          rk;
    int          rkc;

    #1;
    check_output("reset busy", 32'(busy), 32'(0));
    check_output("reset hi", hi, 32'h0);
    check_output("reset lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    apply_stimulus(4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    apply_stimulus(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    apply_stimulus(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    apply_stimulus(4'd4, 32'h11, 32'd0, 1'b0, 0);
    apply_stimulus(4'd5, 32'h22, 32'd0, 1'b0, 0);
    apply_stimulus(4'd3, 32'd1234, 32'd0, 1'b0, 0);
    apply_stimulus(4'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 3);
    apply_stimulus(4'd1, 32'hCAFE_0001, 32'h0000_FFFF, 1'b0, MULT_LAT);
    apply_stimulus(4'd4, 32'h0, 32'd0, 1'b0, 0);
    apply_stimulus(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    apply_stimulus(4'd6, 32'd1, 32'd1, 1'b0, 0);
    apply_stimulus(4'd0, 32'd7, 32'd9, 1'b1, 0);
    apply_stimulus(4'd4, 32'h77, 32'd0, 1'b1, 0);
    apply_stimulus(4'd12, 32'h55, 32'h66, 1'b0, 0);

    // Asynchronous reset in the fourth busy cycle of a divide.
    apply_stimulus(4'd4, 32'hA5A5_0001, 32'd0, 1'b0, 0);
    wait_idle();
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("busy before reset", 32'(busy), 32'(1));
    #1 reset = 1'b0;
    #1;
    check_output("async reset busy", 32'(busy), 32'(0));
    check_output("async reset hi", hi, 32'h0);
    check_output("async reset lo", lo, 32'h0);
    model_hi = '0; model_lo = '0;
    @(posedge clk); #2 reset = 1'b1;
    apply_stimulus(4'd4, 32'd5, 32'd0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ro  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rk  = ($urandom_range(0, 7) == 0);
      rkc = ($urandom_range(0, 3) == 0) ?
            $urandom_range(1, (ro == 4'd2 || ro == 4'd3) ? DIV_LAT : MULT_LAT) : 0;
      apply_stimulus(ro, ra, rb, rk, rkc);
    end

    wait_idle();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("[TB] FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
